stack_ctrl: RTL
===============

Name: stack_ctrl

Overview:
Controller and arbiter that shares one hardware LIFO between two requesters: requester 0 is the core's register push/pop unit, requester 1 is the call/return sequencer. It owns the stack pointer, the full/empty tracking and the overflow/underflow detection. It drives a storage sub-module with synchronous write and registered read, and executes at most one stack operation per cycle, chosen round-robin.

Parameters:
DATA_W, 14, width of a stack entry
DEPTH, 12, number of entries
CNT_W, 4, width of the pointer/count; must satisfy 2^CNT_W > DEPTH

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous flush; empties the stack
req0  input  1  requester 0 operation request
op0  input  1  requester 0 op: 0 = push, 1 = pop
wdata0  input  DATA_W  requester 0 push data
gnt0  output  1  requester 0 grant (combinational, same cycle)
rsp_valid0  output  1  requester 0 pop data valid
rdata0  output  DATA_W  requester 0 pop data
err0  output  1  requester 0 overflow/underflow flag
req1, op1, wdata1, gnt1, rsp_valid1, rdata1, err1  as above, for requester 1
count  output  CNT_W  current number of entries
empty  output  1  count == 0
full  output  1  count == DEPTH

Behaviour:
- Reset:
  - count = 0, last_grant = 1 (requester 0 wins the first contention).
  - All rsp_valid and err outputs are 0; rdata outputs are 0.
  - Storage contents are don't-care.
- Handshake:
  - A requester holds req, op and wdata stable until it sees gnt high in the same cycle.
  - One gnt cycle consumes exactly one operation.
  - gnt is a combinational function of the req inputs, last_grant, clear and reset.
- Arbitration:
  - If only one requester has req high, grant it.
  - If both have req high, grant the one that is not last_grant.
  - last_grant updates only on a grant.
  - Never grant both requesters in one cycle.
  - No grant while reset or clear is high.
- Pointer semantics: count is also the stack pointer.
  - Push writes mem[count] and sets count+1.
  - Pop reads mem[count-1] and sets count-1.
- Push when not full: the storage write happens on the grant edge; count increments on the same edge.
- Pop when not empty:
  - The read address is issued in the grant cycle; count decrements on the same edge.
  - rsp_valid of the granted requester is high for exactly one cycle, the cycle after grant.
  - rdata is valid in that same cycle and holds its value until the next response to that requester.
- Overflow (push while full) and underflow (pop while empty):
  - The op is still granted and consumed.
  - Storage and count are unchanged.
  - err of that requester pulses for one cycle, the cycle after grant.
  - rsp_valid stays low.
- err and rsp_valid are never high together for the same requester.
- Back-to-back operations:
  - A pop immediately after a push returns the just-pushed value; the write and pointer update complete on the grant edge.
  - Consecutive grants may be issued every cycle.
- clear:
  - count = 0 on the next edge.
  - A response already due from the previous cycle's grant is still delivered.
- reset while a pop is in flight: the pending rsp_valid/err is cancelled and does not appear.
- Widths: count arithmetic is in CNT_W bits; full and empty are exact compares, with no wrap-around.
- Structure: a single state register pair (count, last_grant) plus per-requester response-pending flags; no multi-cycle FSM beyond the one-cycle response pipeline.

Decomposition:
- Shared opcodes header gets the new constants STK_OP_PUSH = 1'b0 and STK_OP_POP = 1'b1, alongside the existing OP_PUSH_R/OP_POP_R.
- One sub-module, stack_mem (DATA_W x DEPTH):
  - synchronous write port (we, waddr, wdata);
  - synchronous read port (re, raddr) with registered rdata, 1-cycle latency;
  - no internal pointer.
- The controller owns all pointer logic.

Test Plan:
- Reset, then req0 pop: expect gnt0 that cycle; next cycle err0=1, rsp_valid0=0; count=0, empty=1.
- req0 pushes 0x0A5 then 0x123, then pops: rsp_valid0=1 with rdata0=0x123 one cycle after the pop grant; count=1. A second pop returns 0x0A5; empty=1.
- req0 and req1 both push continuously (r0 data 0x001, 0x003, …; r1 data 0x002, 0x004, …): expect grants 0,1,0,1 and count 4 after four cycles. Four pops by req1 return 0x004, 0x003, 0x002, 0x001 on rsp_valid1.
- Push 12 values 0x100..0x10B: full=1. A 13th push (0x3FFF) gives err=1 next cycle with count still 12. The next pop returns 0x10B.
- clear asserted with both reqs high: gnt0=gnt1=0; count=0 next cycle. Separately, assert reset in the cycle after a pop grant: rsp_valid stays 0 and count=0.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared opcodes and sizing for the stack controller slice.
package stack_ctrl_pkg;

    localparam int unsigned STK_DATA_W = 14;
    localparam int unsigned STK_DEPTH  = 12;
    localparam int unsigned STK_CNT_W  = 4;

    // Register push/pop unit opcodes
    localparam logic [3:0] OP_PUSH_R = 4'h4;
    localparam logic [3:0] OP_POP_R  = 4'h5;

    localparam logic STK_OP_PUSH = 1'b0;
    localparam logic STK_OP_POP  = 1'b1;

endpackage

// File: rtl/stack_ctrl_if.sv
// One requester port of the shared stack: request/grant handshake plus response.
interface stack_ctrl_if
    import stack_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = STK_DATA_W
);
    logic              req;
    logic              op;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rsp_valid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, op, wdata, input gnt, rsp_valid, rdata, err);
    modport slave  (input req, op, wdata, output gnt, rsp_valid, rdata, err);
endinterface

// File: rtl/stack_mem.sv
// Stack storage: synchronous write, registered read with one-cycle latency.
module stack_mem #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned DEPTH  = 12,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are don't-care after reset, so no reset on the array.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/stack_ctrl.sv
// Two-requester round-robin controller for a shared LIFO; owns pointer and full/empty.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = STK_DATA_W,
    parameter int unsigned DEPTH  = STK_DEPTH,
    parameter int unsigned CNT_W  = STK_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    stack_ctrl_if.slave      rq0,
    stack_ctrl_if.slave      rq1,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    logic [CNT_W-1:0]  count_q, count_d;
    logic              last_q, last_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic              pop0_q, pop0_d, err0_q, err0_d;
    logic              pop1_q, pop1_d, err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              gnt0_c, gnt1_c;
    logic              sel_op;
    logic [DATA_W-1:0] sel_wdata;
    logic              push_ok, pop_ok, op_err;
    logic [DATA_W-1:0] mem_rdata;

    // Round-robin grant: contention goes to whoever was not granted last.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!reset && !clear) begin
            if (rq0.req && (!rq1.req || last_q)) gnt0_c = 1'b1;
            else if (rq1.req)                    gnt1_c = 1'b1;
        end
    end

    always_comb begin
        count_d   = count_q;
        last_d    = last_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        push_ok   = 1'b0;
        pop_ok    = 1'b0;
        op_err    = 1'b0;
        sel_op    = gnt1_c ? rq1.op    : rq0.op;
        sel_wdata = gnt1_c ? rq1.wdata : rq0.wdata;

        if (gnt0_c || gnt1_c) begin
            last_d = gnt1_c;
            if (sel_op == STK_OP_PUSH) push_ok = !full_q;
            else                       pop_ok  = !empty_q;
            op_err = !(push_ok || pop_ok);
        end

        if (clear)        count_d = '0;
        else if (push_ok) count_d = count_q + CNT_W'(1);
        else if (pop_ok)  count_d = count_q - CNT_W'(1);

        pop0_d = gnt0_c && pop_ok;
        err0_d = gnt0_c && op_err;
        pop1_d = gnt1_c && pop_ok;
        err1_d = gnt1_c && op_err;

        // Capture the read data so it survives the other requester's pops.
        if (pop0_q) rdata0_d = mem_rdata;
        if (pop1_q) rdata1_d = mem_rdata;

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            last_q   <= 1'b1;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            pop0_q   <= 1'b0;
            err0_q   <= 1'b0;
            pop1_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            count_q  <= count_d;
            last_q   <= last_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            pop0_q   <= pop0_d;
            err0_q   <= err0_d;
            pop1_q   <= pop1_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (CNT_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_ok),
        .waddr_i (count_q),
        .wdata_i (sel_wdata),
        .re_i    (pop_ok),
        .raddr_i (count_q - CNT_W'(1)),
        .rdata_o (mem_rdata)
    );

    // A reset arriving in the response cycle cancels the pending response.
    assign rq0.gnt       = gnt0_c;
    assign rq1.gnt       = gnt1_c;
    assign rq0.rsp_valid = pop0_q && !reset;
    assign rq1.rsp_valid = pop1_q && !reset;
    assign rq0.err       = err0_q && !reset;
    assign rq1.err       = err1_q && !reset;
    assign rq0.rdata     = pop0_q ? mem_rdata : rdata0_q;
    assign rq1.rdata     = pop1_q ? mem_rdata : rdata1_q;

    assign count = count_q;
    assign empty = empty_q;
    assign full  = full_q;
endmodule
